sha256_block_engine: RTL and testbench

Parametrised multi-block SHA-256 compression engine for the mining datapath. It accepts pre-padded 512-bit message blocks over a valid/ready handshake and chains intermediate hash state across blocks. It computes 1, 2, 4 or 8 rounds per clock and, optionally, performs the Bitcoin SHA-256d second pass internally. It sits between the header/nonce formatter and the target comparator.

---
 rtl/sha256_pkg.sv | 95 +++++++++
 rtl/sha256_round.sv | 21 ++
 rtl/sha256_block_engine.sv | 165 ++++++++++++++++
 tb/tb_sha256_block_engine.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, round functions and engine state type
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMP,
        ST_UPDATE,
        ST_COMP2,
        ST_UPDATE2
    } state_e;

    typedef logic [15:0][31:0] sched_win_t;

    localparam logic [255:0] SHA_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    // Listed in round order, so round 0 lands in the top word of the packed table.
    localparam logic [63:0][31:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] k_const(input logic [5:0] idx);
        return K_TABLE[6'd63 - idx];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Word-wise mod 2^32 sum of two eight-word hash states.
    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    // Index 0 of the window is message word 0, taken from the top of the block.
    function automatic sched_win_t block_to_words(input logic [511:0] blk);
        sched_win_t w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w[i] = blk[511 - 32*i -: 32];
        end
        return w;
    endfunction

    function automatic logic [511:0] second_pass_block(input logic [255:0] h);
        return {h, 32'h80000000, 192'd0, 32'h00000100};
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_block_engine.sv
// rtl/sha256_block_engine.sv - multi-block SHA-256 engine, RPC rounds/clock, optional SHA-256d
module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int unsigned RPC    = 1,
    parameter bit          DOUBLE = 1'b0
) (
    input  logic         CLK,
    input  logic         nreset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    localparam logic [5:0] RPC_W      = 6'(RPC);
    localparam logic [5:0] LAST_ROUND = 6'(64 - RPC);

    state_e       state_q, state_d;
    logic [5:0]   round_q, round_d;
    sched_win_t   w_q, w_d;
    logic [255:0] work_q, work_d;
    logic [255:0] h_q, h_d;
    logic         first_q, first_d;
    logic         last_q, last_d;
    logic [255:0] digest_q, digest_d;
    logic         digest_valid_q, digest_valid_d;
    logic         blk_ready_q, blk_ready_d;
    logic         busy_q, busy_d;

    // Window plus the RPC schedule words generated this cycle; word j feeds round round_q+j.
    logic [16+RPC-1:0][31:0] sched;
    logic [255:0]            final_work;
    logic [255:0]            new_h;

    always_comb begin
        sched = '0;
        sched[15:0] = w_q;
        for (int j = 0; j < RPC; j++) begin
            sched[16+j] = small_sigma1(sched[14+j]) + sched[9+j]
                        + small_sigma0(sched[1+j]) + sched[j];
        end
    end

    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [255:0] s_in;
        logic [255:0] s_out;
        if (j == 0) begin : g_head
            assign s_in = work_q;
        end else begin : g_link
            assign s_in = g_rnd[j-1].s_out;
        end
        sha256_round u_round (
            .state_in  (s_in),
            .k         (k_const(round_q + 6'(j))),
            .w         (sched[j]),
            .state_out (s_out)
        );
    end

    assign final_work = g_rnd[RPC-1].s_out;
    assign new_h      = add_words(first_q ? SHA_IV : h_q, work_q);

    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        w_d            = w_q;
        work_d         = work_q;
        h_d            = h_q;
        first_d        = first_q;
        last_d         = last_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (digest_valid_q && digest_ready) begin
                    digest_valid_d = 1'b0;
                end
                if (blk_valid && blk_ready_q) begin
                    w_d     = block_to_words(blk_data);
                    work_d  = blk_first ? SHA_IV : h_q;
                    first_d = blk_first;
                    last_d  = blk_last;
                    round_d = '0;
                    state_d = ST_COMP;
                end
            end
            ST_COMP, ST_COMP2: begin
                work_d  = final_work;
                w_d     = sched[RPC +: 16];
                round_d = round_q + RPC_W;
                if (round_q == LAST_ROUND) begin
                    state_d = (state_q == ST_COMP) ? ST_UPDATE : ST_UPDATE2;
                end
            end
            ST_UPDATE: begin
                h_d = new_h;
                if (!last_q) begin
                    state_d = ST_IDLE;
                end else if (DOUBLE) begin
                    w_d     = block_to_words(second_pass_block(new_h));
                    work_d  = SHA_IV;
                    round_d = '0;
                    state_d = ST_COMP2;
                end else begin
                    digest_d       = new_h;
                    digest_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            ST_UPDATE2: begin
                // H keeps the first-pass chain; only the digest sees the second pass.
                digest_d       = add_words(SHA_IV, work_q);
                digest_valid_d = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        blk_ready_d = (state_d == ST_IDLE) && !digest_valid_d;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            state_q        <= ST_IDLE;
            round_q        <= '0;
            w_q            <= '0;
            work_q         <= '0;
            h_q            <= SHA_IV;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            blk_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            w_q            <= w_d;
            work_q         <= work_d;
            h_q            <= h_d;
            first_q        <= first_d;
            last_q         <= last_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            blk_ready_q    <= blk_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign blk_ready    = blk_ready_q;
    assign digest_valid = digest_valid_q;
    assign digest       = digest_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sha256_block_engine.sv
// tb/tb_sha256_block_engine.sv - randomized model-checked bench over six RPC/DOUBLE configurations
module tb_sha256_block_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] TB_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV_C =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] TWO_B1 = {
        256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
        192'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
        32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {480'd0, 32'h000001c0};
    localparam logic [255:0] G_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] G_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] G_ABC_D =
        256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight FIPS 180-4 compression of one block onto chain value hin.
    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  s0, s1, t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
            t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TB_K[i] + w[i];
            s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
            t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        r = '0;
        for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
        return r;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [5:0] done;

    for (genvar g = 0; g < 6; g++) begin : g_cfg
        localparam int unsigned RPC_P = (g == 0 || g == 4) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
        localparam bit          DBL_P = (g >= 4);
        localparam int          N_P   = 64 / RPC_P;

        logic         nreset, blk_valid, blk_ready, blk_first, blk_last;
        logic         digest_valid, digest_ready, busy;
        logic [511:0] blk_data;
        logic [255:0] digest;
        int           bp_mode = 0;
        logic         done_l = 1'b0;
        string        nm;

        assign done[g] = done_l;

        sha256_block_engine #(.RPC(RPC_P), .DOUBLE(DBL_P)) u_dut (
            .CLK          (clk),
            .nreset       (nreset),
            .blk_valid    (blk_valid),
            .blk_ready    (blk_ready),
            .blk_data     (blk_data),
            .blk_first    (blk_first),
            .blk_last     (blk_last),
            .digest_valid (digest_valid),
            .digest_ready (digest_ready),
            .digest       (digest),
            .busy         (busy)
        );

        // Consumer: random, held low, or held high depending on bp_mode.
        initial begin
            digest_ready = 1'b0;
            forever begin
                @(posedge clk);
                #2;
                digest_ready = (bp_mode == 0) ? ($urandom_range(0, 3) != 0) : (bp_mode == 2);
            end
        end

        task automatic send(input logic [511:0] d, input logic f, input logic l);
            bit ok = 1'b0;
            blk_data  = d;
            blk_first = f;
            blk_last  = l;
            blk_valid = 1'b1;
            for (int c = 0; c < 1000 && !ok; c++) begin
                @(negedge clk);
                if (blk_ready) begin
                    @(posedge clk);
                    #1;
                    ok = 1'b1;
                end
            end
            blk_valid = 1'b0;
            blk_data  = rand_blk();
            blk_first = 1'($urandom_range(0, 1));
            blk_last  = 1'($urandom_range(0, 1));
            chk({nm, " handshake"}, 256'(ok), 256'd1);
        endtask

        task automatic wait_idle();
            for (int c = 0; c < 3000 && (busy || digest_valid); c++) begin
                @(posedge clk);
                #1;
            end
            chk({nm, " drained"}, 256'({busy, digest_valid}), 256'd0);
        endtask

        initial begin
            int nb;
            nm = $sformatf("cfg%0d", g);
            nreset = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_first = 1'b0; blk_last = 1'b0;
            repeat (3) @(posedge clk);
            #1 nreset = 1'b1;

            send(ABC_BLK, 1'b1, 1'b1);
            wait_idle();
            send(TWO_B1, 1'b1, 1'b0);
            send(TWO_B2, 1'b0, 1'b1);
            wait_idle();

            bp_mode = 1;
            send(ABC_BLK, 1'b1, 1'b1);
            for (int c = 0; c < 400 && !digest_valid; c++) begin
                @(posedge clk);
                #1;
            end
            fork
                send(TWO_B1, 1'b1, 1'b1);
                begin
                    repeat (20) @(posedge clk);
                    #1 bp_mode = 2;
                end
            join
            wait_idle();
            bp_mode = 0;

            send(TWO_B1, 1'b1, 1'b0);
            repeat (N_P / 2 + 1) @(posedge clk);
            #1 nreset = 1'b0;
            @(posedge clk);
            #1 nreset = 1'b1;
            send(rand_blk(), 1'b0, 1'b1);
            wait_idle();
            send(ABC_BLK, 1'b1, 1'b1);
            wait_idle();

            for (int m = 0; m < 6; m++) begin
                nb = int'($urandom_range(1, 3));
                for (int b = 0; b < nb; b++) send(rand_blk(), b == 0, b == nb - 1);
            end
            wait_idle();
            done_l = 1'b1;
        end

        // Cycle model derived from the documented latencies; compared every negedge.
        initial begin
            logic [255:0] mh, md, dd;
            logic [511:0] d_p;
            bit           bm, dvm, has_dig, hs_p, rdy_p, f_p, l_p;
            int           ne, bend;
            mh = IV_C; md = '0; dd = '0; d_p = '0;
            bm = 0; dvm = 0; has_dig = 0; hs_p = 0; rdy_p = 0; f_p = 0; l_p = 0;
            ne = 0; bend = 0;
            forever begin
                @(negedge clk);
                ne++;
                if (!nreset) begin
                    mh = IV_C; md = '0; bm = 0; dvm = 0; has_dig = 0; hs_p = 0;
                end else begin
                    if (dvm && rdy_p) dvm = 0;
                    if (hs_p) begin
                        mh      = sha_compress(f_p ? IV_C : mh, d_p);
                        bm      = 1;
                        has_dig = l_p;
                        bend    = ne + ((l_p && DBL_P) ? 2 * N_P + 2 : N_P + 1);
                        dd      = (l_p && DBL_P)
                                ? sha_compress(IV_C, {mh, 32'h80000000, 192'd0, 32'h00000100}) : mh;
                    end
                    if (bm && ne == bend) begin
                        bm = 0;
                        if (has_dig) begin
                            dvm = 1;
                            md  = dd;
                        end
                    end
                end
                chk({nm, " blk_ready"}, 256'(blk_ready), 256'(!bm && !dvm));
                chk({nm, " busy"}, 256'(busy), 256'(bm));
                chk({nm, " digest_valid"}, 256'(digest_valid), 256'(dvm));
                chk({nm, " digest"}, digest, md);
                hs_p  = nreset && blk_valid && !bm && !dvm;
                d_p   = blk_data;
                f_p   = blk_first;
                l_p   = blk_last;
                rdy_p = digest_ready;
            end
        end
    end

    initial begin
        chk("model abc", sha_compress(IV_C, ABC_BLK), G_ABC);
        chk("model two_block", sha_compress(sha_compress(IV_C, TWO_B1), TWO_B2), G_TWO);
        chk("model abc_sha256d",
            sha_compress(IV_C, {sha_compress(IV_C, ABC_BLK), 32'h80000000, 192'd0, 32'h00000100}),
            G_ABC_D);
        for (int c = 0; c < 60000 && done != 6'h3f; c++) @(posedge clk);
        chk("all configs finished", 256'(done), 256'h3f);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
